// File: rtl/touch_adc_seq.sv
// touch_adc_seq: pen-triggered multi-channel touch ADC sequencer with per-channel averaging, frame pacing and SPI watchdog
module touch_adc_seq #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12,
  parameter int AVG_LOG2 = 2,
  parameter logic [3*NUM_CH-1:0] CH_ADDR = 12'b100_011_001_101,
  parameter int SETTLE = 16,
  parameter int FRAME_GAP = 50000,
  parameter int TIMEOUT = 1024,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ADC_PENIRQ_n,
  input  logic              SPI_DONE,
  input  logic [DATA_W-1:0] SPI_RDATA,
  output logic              ADC_CS,
  output logic              SPI_START,
  output logic [7:0]        SPI_CMD,
  output logic [DATA_W-1:0] SAMPLE,
  output logic [CH_W-1:0]   SAMPLE_CH,
  output logic              SAMPLE_VALID,
  output logic              FRAME_DONE,
  output logic              PEN_DOWN,
  output logic              ERROR
);
  localparam int CMAX = (SETTLE > FRAME_GAP) ? ((SETTLE > TIMEOUT) ? SETTLE : TIMEOUT)
                                             : ((FRAME_GAP > TIMEOUT) ? FRAME_GAP : TIMEOUT);
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(FRAME_GAP - 1);
  localparam logic [CNT_W-1:0] WD_LD = CNT_W'(TIMEOUT - 1);
  localparam logic [AVG_LOG2:0] LAST_N = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_XFER, S_EMIT, S_GAP} state_t;

  state_t              state_q;
  logic                p1_q, p2_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CH_W-1:0]     ch_q;
  logic [AVG_LOG2:0]   n_q;
  logic [ACC_W-1:0]    acc_q;
  logic                cs_q, start_q, valid_q, frame_q, pen_q, err_q;
  logic [7:0]          cmd_q;
  logic [DATA_W-1:0]   sample_q;
  logic [CH_W-1:0]     sample_ch_q;
  logic [CH_W-1:0]     ch_nx;

  function automatic logic [7:0] cmd_of(input logic [CH_W-1:0] c);
    return {1'b1, CH_ADDR[3*c +: 3], 4'b0000};
  endfunction

  assign ch_nx = ch_q + 1'b1;

  // One shared down-counter serves settle, gap and the transfer watchdog
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      p1_q <= 1'b1;
      p2_q <= 1'b1;
      cnt_q <= '0;
      ch_q <= '0;
      n_q <= '0;
      acc_q <= '0;
      cs_q <= 1'b0;
      start_q <= 1'b0;
      cmd_q <= '0;
      sample_q <= '0;
      sample_ch_q <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      pen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      p1_q <= ADC_PENIRQ_n;
      p2_q <= p1_q;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (!p2_q) begin
          state_q <= S_SETTLE;
          pen_q <= 1'b1;
          cs_q <= 1'b1;
          cnt_q <= SETTLE_LD;
        end
        S_SETTLE: if (cnt_q == '0) begin
          state_q <= S_XFER;
          ch_q <= '0;
          n_q <= '0;
          acc_q <= '0;
          start_q <= 1'b1;
          cmd_q <= cmd_of('0);
          cnt_q <= WD_LD;
        end else cnt_q <= cnt_q - 1'b1;
        S_XFER: if (SPI_DONE && !start_q) begin
          acc_q <= acc_q + ACC_W'(SPI_RDATA);
          n_q <= n_q + 1'b1;
          if (n_q == LAST_N) state_q <= S_EMIT;
          else begin
            start_q <= 1'b1;
            cnt_q <= WD_LD;
          end
        end else if (cnt_q == '0) begin
          state_q <= S_GAP;
          err_q <= 1'b1;
          acc_q <= '0;
          n_q <= '0;
          cs_q <= 1'b0;
          cnt_q <= GAP_LD;
        end else cnt_q <= cnt_q - 1'b1;
        S_EMIT: begin
          sample_q <= acc_q[ACC_W-1 -: DATA_W];
          sample_ch_q <= ch_q;
          valid_q <= 1'b1;
          acc_q <= '0;
          n_q <= '0;
          if (ch_q == LAST_CH) begin
            state_q <= S_GAP;
            frame_q <= 1'b1;
            cs_q <= 1'b0;
            cnt_q <= GAP_LD;
          end else begin
            state_q <= S_XFER;
            ch_q <= ch_nx;
            start_q <= 1'b1;
            cmd_q <= cmd_of(ch_nx);
            cnt_q <= WD_LD;
          end
        end
        S_GAP: if (cnt_q == '0) begin
          if (!p2_q) begin
            state_q <= S_SETTLE;
            ch_q <= '0;
            cs_q <= 1'b1;
            cnt_q <= SETTLE_LD;
          end else begin
            state_q <= S_IDLE;
            pen_q <= 1'b0;
          end
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ADC_CS = cs_q;
  assign SPI_START = start_q;
  assign SPI_CMD = cmd_q;
  assign SAMPLE = sample_q;
  assign SAMPLE_CH = sample_ch_q;
  assign SAMPLE_VALID = valid_q;
  assign FRAME_DONE = frame_q;
  assign PEN_DOWN = pen_q;
  assign ERROR = err_q;
endmodule

// File: tb/tb_touch_adc_seq.sv
// tb_touch_adc_seq: directed checks of touch_adc_seq in 4-channel, averaging and single-channel builds
module tb_touch_adc_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, pen_n, done, cs, start, valid, frame, pen, err;
  logic [11:0] rdata [3];
  logic [11:0] sample [3];
  logic [7:0] cmd [3];
  logic [1:0] sch0, sch1;
  logic sch2;
  int tests = 0;
  int fails = 0;
  logic [7:0] cmd_tab [4] = '{8'hD0, 8'h90, 8'hB0, 8'hC0};
  logic [11:0] dat_tab [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};

  touch_adc_seq #(.AVG_LOG2(0), .SETTLE(4), .FRAME_GAP(8), .TIMEOUT(16)) u0 (
    .CLK(clk), .RST(rst[0]), .ADC_PENIRQ_n(pen_n[0]), .SPI_DONE(done[0]), .SPI_RDATA(rdata[0]),
    .ADC_CS(cs[0]), .SPI_START(start[0]), .SPI_CMD(cmd[0]), .SAMPLE(sample[0]), .SAMPLE_CH(sch0),
    .SAMPLE_VALID(valid[0]), .FRAME_DONE(frame[0]), .PEN_DOWN(pen[0]), .ERROR(err[0]));

  touch_adc_seq #(.AVG_LOG2(2), .SETTLE(4), .FRAME_GAP(8), .TIMEOUT(16)) u1 (
    .CLK(clk), .RST(rst[1]), .ADC_PENIRQ_n(pen_n[1]), .SPI_DONE(done[1]), .SPI_RDATA(rdata[1]),
    .ADC_CS(cs[1]), .SPI_START(start[1]), .SPI_CMD(cmd[1]), .SAMPLE(sample[1]), .SAMPLE_CH(sch1),
    .SAMPLE_VALID(valid[1]), .FRAME_DONE(frame[1]), .PEN_DOWN(pen[1]), .ERROR(err[1]));

  touch_adc_seq #(.NUM_CH(1), .CH_ADDR(3'b101), .AVG_LOG2(0), .SETTLE(4), .FRAME_GAP(8), .TIMEOUT(16)) u2 (
    .CLK(clk), .RST(rst[2]), .ADC_PENIRQ_n(pen_n[2]), .SPI_DONE(done[2]), .SPI_RDATA(rdata[2]),
    .ADC_CS(cs[2]), .SPI_START(start[2]), .SPI_CMD(cmd[2]), .SAMPLE(sample[2]), .SAMPLE_CH(sch2),
    .SAMPLE_VALID(valid[2]), .FRAME_DONE(frame[2]), .PEN_DOWN(pen[2]), .ERROR(err[2]));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(input int d, output bit ok);
    int n = 0;
    while (start[d] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ok = (start[d] === 1'b1);
  endtask

  task automatic pulse_done(input int d, input logic [11:0] data, input int dly);
    repeat (dly) tick();
    rdata[d] = data;
    done[d] = 1'b1;
    tick();
    done[d] = 1'b0;
    rdata[d] = '0;
  endtask

  task automatic test_reset();
    rst = '1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({cs[d], start[d], valid[d], frame[d], pen[d], err[d]} !== 6'b0 || cmd[d] !== 8'h00 || sample[d] !== 12'h000) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: cs,start,valid,frame,pen,err=%b cmd=%h sample=%h, required all zero",
                 d, {cs[d], start[d], valid[d], frame[d], pen[d], err[d]}, cmd[d], sample[d]);
      end
    end
    tests++;
    if ({sch0, sch1, sch2} !== 5'b0) begin
      fails++;
      $display("FAIL reset_sample_ch: got %b, required 00000", {sch0, sch1, sch2});
    end
    rst = '0;
  endtask

  task automatic test_glitch_idle();
    int nact = 0;
    int nv = 0;
    repeat (4) tick();
    @(posedge clk);
    #1 pen_n[0] = 1'b0;
    #2 pen_n[0] = 1'b1;
    tick();
    rdata[0] = 12'hFFF;
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    rdata[0] = '0;
    repeat (10) begin
      tick();
      if (cs[0] !== 1'b0 || start[0] !== 1'b0 || pen[0] !== 1'b0) nact++;
      if (valid[0] !== 1'b0) nv++;
    end
    tests++;
    if (nact != 0) begin
      fails++;
      $display("FAIL glitch_idle: %0d active cycles, required 0", nact);
    end
    tests++;
    if (nv != 0) begin
      fails++;
      $display("FAIL done_in_idle: %0d SAMPLE_VALID cycles, required 0", nv);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    logic c1, c2, c3, s_early, s1;
    int n = 0;
    pen_n[0] = 1'b0;
    tick(); c1 = cs[0];
    tick(); c2 = cs[0];
    tick(); c3 = cs[0];
    tests++;
    if ({c1, c2, c3} !== 3'b001 || pen[0] !== 1'b1) begin
      fails++;
      $display("FAIL cs_rise: cs after edges 1..3=%b pen_down=%b, required 001 and 1", {c1, c2, c3}, pen[0]);
    end
    repeat (3) tick();
    s_early = start[0];
    tick();
    tests++;
    if (s_early !== 1'b0 || start[0] !== 1'b1 || cs[0] !== 1'b1) begin
      fails++;
      $display("FAIL settle_len: start at settle 3=%b at 4=%b cs=%b, required 0 1 1", s_early, start[0], cs[0]);
    end
    for (int c = 0; c < 4; c++) begin
      wait_start(0, ok);
      tick();
      s1 = start[0];
      tests++;
      if (!ok || cmd[0] !== cmd_tab[c] || s1 !== 1'b0) begin
        fails++;
        $display("FAIL basic_cmd ch%0d: start=%b cmd=%h next_start=%b, required 1 %h 0", c, ok, cmd[0], s1, cmd_tab[c]);
      end
      pulse_done(0, dat_tab[c], 9);
      tick();
      tests++;
      if (valid[0] !== 1'b1 || sch0 !== 2'(c) || sample[0] !== dat_tab[c] || frame[0] !== (c == 3)) begin
        fails++;
        $display("FAIL basic_sample ch%0d: valid=%b ch=%0d data=%h frame=%b, required 1 %0d %h %b",
                 c, valid[0], sch0, sample[0], frame[0], c, dat_tab[c], c == 3);
      end
    end
    while (cs[0] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL gap_len: ADC_CS low for %0d cycles, required 8", n);
    end
  endtask

  task automatic test_pen_release();
    bit ok;
    logic p7;
    int nv = 0;
    int nact = 0;
    logic [11:0] d2 [4];
    d2 = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
    for (int c = 0; c < 4; c++) begin
      wait_start(0, ok);
      if (c == 0) pen_n[0] = 1'b1;
      tests++;
      if (!ok || cmd[0] !== cmd_tab[c]) begin
        fails++;
        $display("FAIL release_cmd ch%0d: start=%b cmd=%h, required 1 %h", c, ok, cmd[0], cmd_tab[c]);
      end
      pulse_done(0, d2[c], 3);
      tick();
      tests++;
      if (valid[0] !== 1'b1 || sch0 !== 2'(c) || sample[0] !== d2[c] || frame[0] !== (c == 3)) begin
        fails++;
        $display("FAIL release_sample ch%0d: valid=%b ch=%0d data=%h frame=%b, required 1 %0d %h %b",
                 c, valid[0], sch0, sample[0], frame[0], c, d2[c], c == 3);
      end
    end
    tick();
    tick();
    rdata[0] = 12'h555;
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    rdata[0] = '0;
    repeat (4) begin
      tick();
      if (valid[0] !== 1'b0) nv++;
    end
    p7 = pen[0];
    tick();
    tests++;
    if (p7 !== 1'b1 || pen[0] !== 1'b0) begin
      fails++;
      $display("FAIL pen_release: pen_down at gap end-1=%b end=%b, required 1 0", p7, pen[0]);
    end
    repeat (10) begin
      tick();
      if (cs[0] !== 1'b0 || start[0] !== 1'b0) nact++;
      if (valid[0] !== 1'b0) nv++;
    end
    tests++;
    if (nact != 0) begin
      fails++;
      $display("FAIL idle_after_release: %0d active cycles, required 0", nact);
    end
    tests++;
    if (nv != 0) begin
      fails++;
      $display("FAIL done_in_gap: %0d SAMPLE_VALID cycles, required 0", nv);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    logic e15, e16;
    int n = 0;
    int nv = 0;
    int nf = 0;
    pen_n[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      wait_start(0, ok);
      pulse_done(0, dat_tab[c], 2);
      tick();
      tests++;
      if (!ok || valid[0] !== 1'b1 || sch0 !== 2'(c) || sample[0] !== dat_tab[c]) begin
        fails++;
        $display("FAIL wd_pre_sample ch%0d: start=%b valid=%b ch=%0d data=%h, required 1 1 %0d %h",
                 c, ok, valid[0], sch0, sample[0], c, dat_tab[c]);
      end
    end
    wait_start(0, ok);
    tests++;
    if (!ok || cmd[0] !== 8'hB0) begin
      fails++;
      $display("FAIL wd_cmd ch2: start=%b cmd=%h, required 1 b0", ok, cmd[0]);
    end
    repeat (15) tick();
    e15 = err[0];
    tick();
    tests++;
    if (e15 !== 1'b0 || err[0] !== 1'b1 || cs[0] !== 1'b0) begin
      fails++;
      $display("FAIL wd_expiry: error at 15=%b at 16=%b cs=%b, required 0 1 0", e15, err[0], cs[0]);
    end
    tick();
    tests++;
    if (err[0] !== 1'b0) begin
      fails++;
      $display("FAIL wd_pulse: error=%b one cycle later, required 0", err[0]);
    end
    while (start[0] !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (valid[0] === 1'b1) nv++;
      if (frame[0] === 1'b1) nf++;
    end
    tests++;
    if (n != 11 || cmd[0] !== 8'hD0 || nv != 0 || nf != 0) begin
      fails++;
      $display("FAIL wd_restart: cycles=%0d cmd=%h samples=%0d frames=%0d, required 11 d0 0 0", n, cmd[0], nv, nf);
    end
    pulse_done(0, 12'h3C3, 15);
    e16 = err[0];
    tick();
    tests++;
    if (e16 !== 1'b0 || err[0] !== 1'b0 || valid[0] !== 1'b1 || sample[0] !== 12'h3C3 || sch0 !== 2'd0) begin
      fails++;
      $display("FAIL wd_done_wins: error=%b,%b valid=%b data=%h ch=%0d, required 0,0 1 3c3 0",
               e16, err[0], valid[0], sample[0], sch0);
    end
    pen_n[0] = 1'b1;
  endtask

  task automatic test_averaging();
    bit ok;
    logic [11:0] av [4];
    av = '{12'd100, 12'd101, 12'd102, 12'd104};
    pen_n[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_start(1, ok);
      tests++;
      if (!ok || cmd[1] !== 8'hD0) begin
        fails++;
        $display("FAIL avg_cmd conv%0d: start=%b cmd=%h, required 1 d0", i, ok, cmd[1]);
      end
      pulse_done(1, av[i], 2);
      if (i < 3) begin
        tests++;
        if (start[1] !== 1'b1 || valid[1] !== 1'b0) begin
          fails++;
          $display("FAIL avg_restart conv%0d: start=%b valid=%b after DONE, required 1 0", i, start[1], valid[1]);
        end
      end
    end
    tick();
    tests++;
    if (valid[1] !== 1'b1 || sample[1] !== 12'd101 || sch1 !== 2'd0 || frame[1] !== 1'b0) begin
      fails++;
      $display("FAIL avg_sample: valid=%b data=%0d ch=%0d frame=%b, required 1 101 0 0", valid[1], sample[1], sch1, frame[1]);
    end
    tests++;
    if (start[1] !== 1'b1 || cmd[1] !== 8'h90) begin
      fails++;
      $display("FAIL avg_next_ch: start=%b cmd=%h, required 1 90", start[1], cmd[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nact = 0;
    logic [11:0] av [4];
    av = '{12'd10, 12'd20, 12'd30, 12'd41};
    pulse_done(1, 12'hFFF, 2);
    rst[1] = 1'b1;
    pen_n[1] = 1'b1;
    tick();
    tests++;
    if ({cs[1], start[1], valid[1], frame[1], pen[1], err[1]} !== 6'b0 || cmd[1] !== 8'h00 || sample[1] !== 12'h000 || sch1 !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid: cs,start,valid,frame,pen,err=%b cmd=%h sample=%h ch=%0d, required all zero",
               {cs[1], start[1], valid[1], frame[1], pen[1], err[1]}, cmd[1], sample[1], sch1);
    end
    rst[1] = 1'b0;
    rdata[1] = 12'h0AA;
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
    rdata[1] = '0;
    repeat (8) begin
      tick();
      if (cs[1] !== 1'b0 || start[1] !== 1'b0 || valid[1] !== 1'b0) nact++;
    end
    tests++;
    if (nact != 0) begin
      fails++;
      $display("FAIL late_done: %0d active cycles, required 0", nact);
    end
    pen_n[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_start(1, ok);
      tests++;
      if (!ok || cmd[1] !== 8'hD0) begin
        fails++;
        $display("FAIL post_reset_cmd conv%0d: start=%b cmd=%h, required 1 d0", i, ok, cmd[1]);
      end
      pulse_done(1, av[i], 1);
    end
    tick();
    tests++;
    if (valid[1] !== 1'b1 || sample[1] !== 12'd25 || sch1 !== 2'd0) begin
      fails++;
      $display("FAIL post_reset_avg: valid=%b data=%0d ch=%0d, required 1 25 0", valid[1], sample[1], sch1);
    end
    pen_n[1] = 1'b1;
  endtask

  task automatic test_single_ch();
    bit ok;
    logic [11:0] sd [2];
    sd = '{12'h5A5, 12'h0F0};
    pen_n[2] = 1'b0;
    for (int f = 0; f < 2; f++) begin
      wait_start(2, ok);
      tests++;
      if (!ok || cmd[2] !== 8'hD0) begin
        fails++;
        $display("FAIL single_cmd frame%0d: start=%b cmd=%h, required 1 d0", f, ok, cmd[2]);
      end
      pulse_done(2, sd[f], 4);
      tick();
      tests++;
      if (valid[2] !== 1'b1 || sch2 !== 1'b0 || sample[2] !== sd[f] || frame[2] !== 1'b1 || cs[2] !== 1'b0) begin
        fails++;
        $display("FAIL single_sample frame%0d: valid=%b ch=%b data=%h frame=%b cs=%b, required 1 0 %h 1 0",
                 f, valid[2], sch2, sample[2], frame[2], cs[2], sd[f]);
      end
    end
    pen_n[2] = 1'b1;
  endtask

  initial begin
    rst = '1;
    pen_n = '1;
    done = '0;
    for (int i = 0; i < 3; i++) rdata[i] = '0;
    test_reset();
    test_glitch_idle();
    test_basic_frame();
    test_pen_release();
    test_watchdog();
    test_averaging();
    test_reset_mid();
    test_single_ch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
